sram_arbiter: RTL
=================

# sram_arbiter

Sequences and shares the board's two external 256K x 16 asynchronous SRAMs between two internal requesters, for example the SPI block engine filling a buffer and the UART dumper draining it. Presents one 32-bit word-addressed memory: chip 1 is lanes 0-1 (bits 15:0) and chip 2 is lanes 2-3 (bits 31:16). The block generates all SRAM strobes from registers, so there are no glitches. Two-way round-robin grants, one transaction at a time.

## Interface
- READ_CYCLES, 2: cycles oe_l is low before read data is captured (≥1).
- WE_CYCLES, 1: cycles we_l is low per write (≥1).
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; synchronous, active-high.
- pN_req  in  1  request, N∈{0,1}; held high until pN_ack.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  18  word address.
- pN_wdata  in  32  write data.
- pN_be  in  4  byte-lane enables.
- pN_ack  out  1  one-cycle completion pulse.
- pN_rdata  out  32  read data; valid in the ack cycle and held until the next read completes on that port.
- addr  out  18  SRAM address, shared by both chips.
- data1, data2  inout  16  SRAM data buses (chip 1 and chip 2).
- oe_l, we_l  out  1  shared output-enable and write-enable, active-low.
- ce1_l, ub1_l, lb1_l, ce2_l, ub2_l, lb2_l  out  1  per-chip chip-enable and byte strobes, active-low.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- **IDLE:** if any req is high, grant a port and latch its we, addr, wdata, be and port id.
  - Next state is RD for a read, WR_SETUP for a write.
- **Round-robin:** if both ports request, grant the port not granted last. The last-granted pointer resets to 1, so port 0 wins the first tie.
- **Lane mapping:** be[0]→lb1_l, be[1]→ub1_l, be[2]→lb2_l, be[3]→ub2_l.
  - ce1_l is low only if be[1:0]≠0; ce2_l is low only if be[3:2]≠0.
- **RD:** ce/ub/lb per be and oe_l=0 for READ_CYCLES cycles.
  - On the last RD edge, capture {data2,data1} into the granted port's rdata.
  - Lanes with be=0 capture as 0.
- **WR_SETUP:** 1 cycle; addr, ce and strobes asserted; oe_l=1; we_l=1; data buses driven.
- **WR_PULSE:** WE_CYCLES cycles with we_l=0.
- **WR_HOLD:** 1 cycle; we_l=1; addr and data still driven.
- **DONE:** 1 cycle; all strobes high, buses released, granted port's ack=1; next state IDLE.
- **Bus drive:** data1/data2 are driven only in WR_SETUP, WR_PULSE and WR_HOLD, otherwise high-Z. oe_l is never low in a write state.
- **be=0 request:** runs the full sequence with no chip enabled; ack is still issued.
- **Requester changes after grant:** ignored (fields are latched).

## Timing
- **Reset (at the edge with rst=1):**
  - state=IDLE.
  - All *_l outputs = 1, addr=0, data buses high-Z.
  - acks=0, rdata=0, pointer=1.
- **Reset mid-transaction:** aborts at the next edge; no ack; SRAM contents undefined only for an aborted write.
- **Read latency:** req first high in cycle N → RD in cycles N+1..N+READ_CYCLES → ack in N+READ_CYCLES+1 (N+3 by default).
- **Write latency:** ack in N+WE_CYCLES+3 (N+4 by default).
- **Requester rule:** drop req (or present the next command) in the cycle after ack. IDLE samples in the ack+1 cycle, so a req still high there is a new request.
- **Back-to-back throughput:** one read per READ_CYCLES+2 cycles.
- **Simultaneous requests:** both high in IDLE → one granted; the other waits and is granted in the IDLE that follows DONE.

## Structure
- Package sram_arb_pkg holds:
  - the state enum;
  - the lane-to-strobe mapping constants;
  - SRAM_AW=18 and WORD_W=32.
- One sub-module, rr_arb2: 2-way round-robin grant with pointer update on accept.
- Everything else stays in sram_arbiter; total about 200 lines.

## Test plan
- **Reset defaults:** assert rst 2 cycles mid-write → no ack; all _l outputs high; data high-Z; pointer reset (next tie goes to port 0).
- **Full-word round trip:** p0 writes 0xDEADBEEF to addr 0x00010 with be=F → ack at N+4; p0 reads 0x00010 → rdata=0xDEADBEEF, ack at N+3.
- **Byte lanes:** write 0x11223344 with be=F, then 0xAABBCCDD with be=0101b to the same address → read with be=F returns 0x11BB33DD. During the be=0011b read, ce2_l stays 1 and lanes 3:2 read as 0.
- **Arbitration:** both ports request reads every cycle → grants alternate 0,1,0,1 and neither port waits more than one transaction.
- **Protocol check:** on every cycle, never oe_l=0 with we_l=0, and data buses are high-Z outside write states. Repeat with READ_CYCLES=3, WE_CYCLES=2 and confirm the latencies scale.
- **Address extremes:** write and read back 0x3FFFF and 0x00000 → both correct, with no aliasing.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the dual-port external SRAM arbiter.
package sram_arb_pkg;
   localparam int SRAM_AW = 18;
   localparam int WORD_W  = 32;
   localparam int BE_W    = WORD_W / 8;

   // Byte-enable bit that drives each per-chip byte strobe
   localparam int LANE_LB1 = 0;
   localparam int LANE_UB1 = 1;
   localparam int LANE_LB2 = 2;
   localparam int LANE_UB2 = 3;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } state_t;

   typedef struct packed {
      logic oe_l;
      logic we_l;
      logic ce1_l;
      logic ub1_l;
      logic lb1_l;
      logic ce2_l;
      logic ub2_l;
      logic lb2_l;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '1;

   function automatic logic is_write_state(input state_t s);
      return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
   endfunction

   function automatic logic [WORD_W-1:0] lane_mask(input logic [BE_W-1:0] be);
      logic [WORD_W-1:0] m;
      m = '0;
      for (int i = 0; i < BE_W; i++) begin
         m[i*8 +: 8] = {8{be[i]}};
      end
      return m;
   endfunction
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer moves only when a grant is accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       valid,
   output logic       sel
);
   logic last_reg;

   always_comb begin
      valid = |req;
      sel   = 1'b0;
      if (req[0] && req[1]) begin
         sel = ~last_reg;
      end else if (req[1]) begin
         sel = 1'b1;
      end
   end

   // Pointer resets to 1 so port 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg <= 1'b1;
      end else if (accept && valid) begin
         last_reg <= sel;
      end
   end
endmodule

// File: rtl/sram_arbiter.sv
// Shares two 256K x 16 asynchronous SRAMs (one 32-bit word) between two requesters.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int READ_CYCLES = 2,
   parameter int WE_CYCLES   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               p0_req,
   input  logic               p0_we,
   input  logic [SRAM_AW-1:0] p0_addr,
   input  logic [WORD_W-1:0]  p0_wdata,
   input  logic [BE_W-1:0]    p0_be,
   output logic               p0_ack,
   output logic [WORD_W-1:0]  p0_rdata,
   input  logic               p1_req,
   input  logic               p1_we,
   input  logic [SRAM_AW-1:0] p1_addr,
   input  logic [WORD_W-1:0]  p1_wdata,
   input  logic [BE_W-1:0]    p1_be,
   output logic               p1_ack,
   output logic [WORD_W-1:0]  p1_rdata,
   output logic [SRAM_AW-1:0] addr,
   inout  wire  [15:0]        data1,
   inout  wire  [15:0]        data2,
   output logic               oe_l,
   output logic               we_l,
   output logic               ce1_l,
   output logic               ub1_l,
   output logic               lb1_l,
   output logic               ce2_l,
   output logic               ub2_l,
   output logic               lb2_l
);
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

   logic [1:0]         req_vec;
   logic               we_in    [2];
   logic [SRAM_AW-1:0] addr_in  [2];
   logic [WORD_W-1:0]  wdata_in [2];
   logic [BE_W-1:0]    be_in    [2];

   assign req_vec     = {p1_req, p0_req};
   assign we_in[0]    = p0_we;
   assign we_in[1]    = p1_we;
   assign addr_in[0]  = p0_addr;
   assign addr_in[1]  = p1_addr;
   assign wdata_in[0] = p0_wdata;
   assign wdata_in[1] = p1_wdata;
   assign be_in[0]    = p0_be;
   assign be_in[1]    = p1_be;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [SRAM_AW-1:0] addr_reg;
   logic [WORD_W-1:0]  wdata_reg;
   logic [BE_W-1:0]    be_reg, be_next;
   logic               port_reg, port_next;
   strobe_t            strobe_reg, strobe_next;
   logic               drive_reg, drive_next;
   logic [1:0]         ack_reg, ack_next;
   logic [WORD_W-1:0]  rdata_reg [2];
   logic               arb_valid, arb_sel, accept, access;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst    (rst),
      .req    (req_vec),
      .accept (accept),
      .valid  (arb_valid),
      .sel    (arb_sel)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (arb_valid) begin
               accept     = 1'b1;
               cnt_next   = '0;
               state_next = we_in[arb_sel] ? WR_SETUP : RD;
            end
         end
         RD: begin
            if (cnt_reg == RD_LAST) state_next = DONE;
            else                    cnt_next   = cnt_reg + 1'b1;
         end
         WR_SETUP: begin
            state_next = WR_PULSE;
            cnt_next   = '0;
         end
         WR_PULSE: begin
            if (cnt_reg == WE_LAST) state_next = WR_HOLD;
            else                    cnt_next   = cnt_reg + 1'b1;
         end
         WR_HOLD: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes, bus enable and ack are computed for the upcoming state and registered, so the pins never glitch
   always_comb begin
      be_next     = accept ? be_in[arb_sel] : be_reg;
      port_next   = accept ? arb_sel : port_reg;
      access      = (state_next == RD) || is_write_state(state_next);
      strobe_next = STROBE_IDLE;
      if (access) begin
         strobe_next.lb1_l = ~be_next[LANE_LB1];
         strobe_next.ub1_l = ~be_next[LANE_UB1];
         strobe_next.lb2_l = ~be_next[LANE_LB2];
         strobe_next.ub2_l = ~be_next[LANE_UB2];
         strobe_next.ce1_l = ~(be_next[LANE_LB1] | be_next[LANE_UB1]);
         strobe_next.ce2_l = ~(be_next[LANE_LB2] | be_next[LANE_UB2]);
      end
      strobe_next.oe_l = (state_next != RD);
      strobe_next.we_l = (state_next != WR_PULSE);
      drive_next       = is_write_state(state_next);
      ack_next         = '0;
      if (state_next == DONE) ack_next[port_next] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         be_reg       <= '0;
         port_reg     <= 1'b0;
         strobe_reg   <= STROBE_IDLE;
         drive_reg    <= 1'b0;
         ack_reg      <= '0;
         rdata_reg[0] <= '0;
         rdata_reg[1] <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         be_reg     <= be_next;
         port_reg   <= port_next;
         strobe_reg <= strobe_next;
         drive_reg  <= drive_next;
         ack_reg    <= ack_next;
         if (accept) begin
            addr_reg  <= addr_in[arb_sel];
            wdata_reg <= wdata_in[arb_sel];
         end
         // Disabled lanes float on the bus, so they are forced to zero on capture
         if (state_reg == RD && cnt_reg == RD_LAST) begin
            rdata_reg[port_reg] <= {data2, data1} & lane_mask(be_reg);
         end
      end
   end

   assign data1 = drive_reg ? wdata_reg[15:0]  : 16'hzzzz;
   assign data2 = drive_reg ? wdata_reg[31:16] : 16'hzzzz;

   assign addr     = addr_reg;
   assign oe_l     = strobe_reg.oe_l;
   assign we_l     = strobe_reg.we_l;
   assign ce1_l    = strobe_reg.ce1_l;
   assign ub1_l    = strobe_reg.ub1_l;
   assign lb1_l    = strobe_reg.lb1_l;
   assign ce2_l    = strobe_reg.ce2_l;
   assign ub2_l    = strobe_reg.ub2_l;
   assign lb2_l    = strobe_reg.lb2_l;
   assign p0_ack   = ack_reg[0];
   assign p1_ack   = ack_reg[1];
   assign p0_rdata = rdata_reg[0];
   assign p1_rdata = rdata_reg[1];
endmodule
